// File: rtl/sa_request_arbiter.sv
// Switch-allocator request arbiter. Input buffers compete round-robin for the
// single allocator request path. The allocator's registered response (one
// cycle later) moves the winner to GRANTED, or to BACKOFF on a failure.

// Per-buffer request FSM: IDLE -> PENDING -> GRANTED | BACKOFF -> IDLE
module sa_arb_lane #(
  parameter int RETRY_DELAY = 2,
  parameter int CW          = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_req_valid,
  input  logic i_issue,
  input  logic i_resp_hit,
  input  logic i_resp_failed,
  output logic o_idle,
  output logic o_granted
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_BACK  = 2'd2;
  localparam logic [1:0] S_GRANT = 2'd3;

  // Backoff counts RETRY_DELAY-1 down to 0, leaving RETRY_DELAY idle cycles.
  localparam int            RD_M1    = (RETRY_DELAY > 0) ? RETRY_DELAY - 1 : 0;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_M1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;

  // State and backoff counter update
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (i_issue) r_state <= S_PEND;
        S_PEND: begin
          if (i_resp_hit) begin
            if (!i_resp_failed)
              // If the buffer already let go, the allocator frees the slot itself.
              r_state <= i_req_valid ? S_GRANT : S_IDLE;
            else if (RETRY_DELAY > 0) begin
              r_state <= S_BACK;
              r_cnt   <= CNT_INIT;
            end else
              r_state <= S_IDLE;
          end
        end
        S_BACK: begin
          if (!i_req_valid || r_cnt == '0) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else
            r_cnt <= r_cnt - 1'b1;
        end
        S_GRANT: if (!i_req_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_idle    = (r_state == S_IDLE);
  assign o_granted = (r_state == S_GRANT);
endmodule

module sa_request_arbiter #(
  parameter  int NUM_BUFFERS  = 4,
  parameter  int NUM_OUTPORTS = 4,
  parameter  int NUM_VCS      = 2,
  parameter  int RETRY_DELAY  = 2,
  localparam int BW = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1),
  localparam int PW = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1),
  localparam int VW = $clog2(NUM_VCS) + (NUM_VCS == 1),
  localparam int CW = $clog2(RETRY_DELAY + 1) + (RETRY_DELAY == 0)
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_BUFFERS-1:0]          req_valid,
  input  logic [NUM_BUFFERS-1:0][PW-1:0]  req_egress_port,
  input  logic [NUM_BUFFERS-1:0][VW-1:0]  req_vc,
  output logic [NUM_BUFFERS-1:0]          req_granted,
  output logic                            sa_valid,
  output logic [BW-1:0]                   sa_ingress_port,
  output logic [PW-1:0]                   sa_egress_port,
  output logic [VW-1:0]                   sa_final_vc,
  input  logic                            resp_valid,
  input  logic [BW-1:0]                   resp_ingress_port,
  input  logic                            resp_failed
);
  logic [BW-1:0]          r_rr_ptr;
  logic [NUM_BUFFERS-1:0] w_idle;
  logic [NUM_BUFFERS-1:0] w_elig;
  logic                   w_found;
  logic [BW-1:0]          w_win;

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_lane
    sa_arb_lane #(.RETRY_DELAY(RETRY_DELAY), .CW(CW)) u_lane (
      .clk           (clk),
      .n_rst         (n_rst),
      .i_req_valid   (req_valid[g]),
      .i_issue       (w_found && (w_win == BW'(g))),
      .i_resp_hit    (resp_valid && (resp_ingress_port == BW'(g))),
      .i_resp_failed (resp_failed),
      .o_idle        (w_idle[g]),
      .o_granted     (req_granted[g])
    );
  end

  // Gate with reset so nothing issues while the FSMs are held in reset.
  assign w_elig = req_valid & w_idle & {NUM_BUFFERS{n_rst}};

  // Round-robin scan from r_rr_ptr upward, wrapping; first eligible wins
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = BW'(idx);
      end
    end
  end

  assign sa_valid        = w_found;
  assign sa_ingress_port = w_found ? w_win : '0;
  assign sa_egress_port  = w_found ? req_egress_port[w_win] : '0;
  assign sa_final_vc     = w_found ? req_vc[w_win] : '0;

  // Pointer moves past the winner on every issue, holds otherwise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_rr_ptr <= '0;
    else if (w_found)
      r_rr_ptr <= (w_win == BW'(NUM_BUFFERS - 1)) ? '0 : w_win + 1'b1;
  end
endmodule

// File: tb/tb_sa_request_arbiter.sv
// Bench for sa_request_arbiter: directed scenarios plus a randomized run, all
// checked against a cycle-level reference model that tracks grants, pending
// requests and a "blocked until cycle N" time for failed buffers.
module tb_sa_request_arbiter;
  localparam int NB = 4, PW = 2, VW = 1, BW = 2, RD = 2;

  logic clk = 1'b0;
  logic n_rst;
  logic [NB-1:0]         req_valid;
  logic [NB-1:0][PW-1:0] req_egress_port;
  logic [NB-1:0][VW-1:0] req_vc;
  logic [NB-1:0]         req_granted;
  logic                  sa_valid;
  logic [BW-1:0]         sa_ingress_port;
  logic [PW-1:0]         sa_egress_port;
  logic [VW-1:0]         sa_final_vc;
  logic                  resp_valid;
  logic [BW-1:0]         resp_ingress_port;
  logic                  resp_failed;

  int total = 0, bad = 0;

  sa_request_arbiter #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(4), .NUM_VCS(2), .RETRY_DELAY(RD)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_egress_port(req_egress_port),
    .req_vc(req_vc), .req_granted(req_granted), .sa_valid(sa_valid),
    .sa_ingress_port(sa_ingress_port), .sa_egress_port(sa_egress_port),
    .sa_final_vc(sa_final_vc), .resp_valid(resp_valid),
    .resp_ingress_port(resp_ingress_port), .resp_failed(resp_failed)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int      m_ptr, m_last, cyc;
  bit      m_gr   [NB];
  bit      m_pend [NB];
  int      m_until[NB];
  logic          exp_valid;
  int            exp_win;
  logic [PW-1:0] exp_eg;
  logic [VW-1:0] exp_vc;
  logic [NB-1:0] exp_gr;

  function automatic void model_reset();
    m_ptr = 0; m_last = -1;
    for (int b = 0; b < NB; b++) begin m_gr[b] = 0; m_pend[b] = 0; m_until[b] = 0; end
  endfunction

  function automatic void model_eval();
    exp_valid = 1'b0; exp_win = 0;
    if (n_rst)
      for (int i = 0; i < NB; i++) begin
        int b;
        b = (m_ptr + i) % NB;
        if (!exp_valid && req_valid[b] && !m_gr[b] && !m_pend[b] && cyc >= m_until[b]) begin
          exp_valid = 1'b1; exp_win = b;
        end
      end
    exp_eg = exp_valid ? req_egress_port[exp_win] : '0;
    exp_vc = exp_valid ? req_vc[exp_win] : '0;
    for (int b = 0; b < NB; b++) exp_gr[b] = m_gr[b];
  endfunction

  function automatic void model_commit();
    int p;
    if (!n_rst) begin model_reset(); return; end
    for (int b = 0; b < NB; b++) begin
      if (m_gr[b] && !req_valid[b]) m_gr[b] = 0;
      if (cyc < m_until[b] && !req_valid[b]) m_until[b] = cyc + 1;
    end
    p = int'(resp_ingress_port);
    if (resp_valid && m_pend[p]) begin
      m_pend[p] = 0;
      if (!resp_failed) m_gr[p] = req_valid[p];
      else m_until[p] = cyc + RD + 1;
    end
    if (exp_valid) begin m_pend[exp_win] = 1; m_ptr = (exp_win + 1) % NB; end
    m_last = exp_valid ? exp_win : -1;
    cyc++;
  endfunction

  // Drive one cycle's inputs (just after negedge) and compute expectations.
  task automatic drive(input logic [NB-1:0] r, input logic rv, input int rp, input logic rf);
    req_valid = r; resp_valid = rv; resp_ingress_port = BW'(rp); resp_failed = rf;
    #1 model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; model_reset();
    req_valid = '0; resp_valid = 1'b0; resp_ingress_port = '0; resp_failed = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0; model_reset();
    drive(4'b1111, 1'b0, 0, 1'b0);
    total++; if (sa_valid !== 1'b0) begin bad++; $display("FAIL reset_sa_valid got=%0b want=0", sa_valid); end
    total++; if (req_granted !== 4'b0) begin bad++; $display("FAIL reset_granted got=%b want=0000", req_granted); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    req_egress_port = '0; req_vc = '0;
    req_egress_port[0] = 2'd2; req_vc[0] = 1'b1;
    drive(4'b0001, 1'b0, 0, 1'b0);
    total++; if ({sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc} !== {1'b1, 2'd0, 2'd2, 1'b1}) begin
      bad++; $display("FAIL basic_issue got v=%0b in=%0d eg=%0d vc=%0d want v=1 in=0 eg=2 vc=1",
                      sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc); end
    tick();
    drive(4'b0001, 1'b1, 0, 1'b0);
    total++; if (sa_valid !== 1'b0) begin bad++; $display("FAIL basic_pending_valid got=%0b want=0", sa_valid); end
    tick();
    drive(4'b0001, 1'b0, 0, 1'b0);
    total++; if (req_granted !== 4'b0001) begin bad++; $display("FAIL basic_granted got=%b want=0001", req_granted); end
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0);
    total++; if (req_granted !== 4'b0000) begin bad++; $display("FAIL basic_release got=%b want=0000", req_granted); end
    tick();
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, k > 0, (k > 0) ? k - 1 : 0, 1'b0);
      total++; if (sa_valid !== 1'b1 || sa_ingress_port !== BW'(k)) begin
        bad++; $display("FAIL rr_order step=%0d got v=%0b in=%0d want v=1 in=%0d", k, sa_valid, sa_ingress_port, k); end
      tick();
    end
    drive(4'b1111, 1'b1, 3, 1'b0);
    total++; if (sa_valid !== 1'b0) begin bad++; $display("FAIL rr_all_busy got=%0b want=0", sa_valid); end
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0);
    total++; if (req_granted !== 4'b1111) begin bad++; $display("FAIL rr_all_granted got=%b want=1111", req_granted); end
    tick();
    drive(4'b1111, 1'b0, 0, 1'b0);
    total++; if (sa_valid !== 1'b1 || sa_ingress_port !== 2'd0) begin
      bad++; $display("FAIL rr_wrap got v=%0b in=%0d want v=1 in=0", sa_valid, sa_ingress_port); end
    tick();
    drive(4'b0000, 1'b1, 0, 1'b0); tick();
  endtask

  task automatic test_backoff();
    do_reset();
    drive(4'b0010, 1'b0, 0, 1'b0);
    total++; if (sa_ingress_port !== 2'd1 || sa_valid !== 1'b1) begin bad++; $display("FAIL backoff_issue got in=%0d want 1", sa_ingress_port); end
    tick();
    drive(4'b0010, 1'b1, 1, 1'b1);
    tick();
    for (int k = 0; k < RD; k++) begin
      drive(4'b0010, 1'b0, 0, 1'b0);
      total++; if (sa_valid !== 1'b0) begin bad++; $display("FAIL backoff_quiet cycle=%0d got=%0b want=0", k, sa_valid); end
      tick();
    end
    drive(4'b0010, 1'b0, 0, 1'b0);
    total++; if (sa_valid !== 1'b1 || sa_ingress_port !== 2'd1) begin
      bad++; $display("FAIL backoff_retry got v=%0b in=%0d want v=1 in=1", sa_valid, sa_ingress_port); end
    tick();
    drive(4'b0000, 1'b1, 1, 1'b0); tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'b0001, 1'b0, 0, 1'b0); tick();
    drive(4'b0000, 1'b1, 0, 1'b0); tick();
    drive(4'b0101, 1'b0, 0, 1'b0);
    total++; if (sa_ingress_port !== 2'd2 || sa_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got in=%0d want 2", sa_ingress_port); end
    tick();
    drive(4'b0101, 1'b1, 2, 1'b0);
    total++; if (sa_ingress_port !== 2'd0 || sa_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got in=%0d want 0", sa_ingress_port); end
    tick();
    drive(4'b0101, 1'b1, 0, 1'b0);
    total++; if (req_granted !== 4'b0100) begin bad++; $display("FAIL b2b_grant2 got=%b want=0100", req_granted); end
    tick();
    drive(4'b0101, 1'b0, 0, 1'b0);
    total++; if (req_granted !== 4'b0101) begin bad++; $display("FAIL b2b_grant_both got=%b want=0101", req_granted); end
    tick();
    drive(4'b0000, 1'b0, 0, 1'b0); tick();
  endtask

  task automatic test_reset_pending();
    do_reset();
    drive(4'b1000, 1'b0, 0, 1'b0);
    total++; if (sa_ingress_port !== 2'd3 || sa_valid !== 1'b1) begin bad++; $display("FAIL rstp_issue got in=%0d want 3", sa_ingress_port); end
    tick();
    n_rst = 1'b0; model_reset();
    drive(4'b1000, 1'b0, 0, 1'b0);
    total++; if (sa_valid !== 1'b0 || req_granted !== 4'b0) begin
      bad++; $display("FAIL rstp_in_reset got v=%0b gr=%b want v=0 gr=0000", sa_valid, req_granted); end
    @(negedge clk);
    n_rst = 1'b1;
    drive(4'b0000, 1'b1, 3, 1'b0);
    tick();
    drive(4'b1000, 1'b0, 0, 1'b0);
    total++; if (req_granted !== 4'b0 || sa_valid !== 1'b1 || sa_ingress_port !== 2'd3) begin
      bad++; $display("FAIL rstp_late_resp got gr=%b v=%0b in=%0d want gr=0000 v=1 in=3", req_granted, sa_valid, sa_ingress_port); end
    tick();
    drive(4'b0000, 1'b1, 3, 1'b0); tick();
  endtask

  task automatic test_stray_resp();
    do_reset();
    drive(4'b0000, 1'b1, 2, 1'b0);
    tick();
    drive(4'b0100, 1'b0, 0, 1'b0);
    total++; if (req_granted[2] !== 1'b0 || sa_valid !== 1'b1 || sa_ingress_port !== 2'd2) begin
      bad++; $display("FAIL stray_resp got gr2=%0b v=%0b in=%0d want gr2=0 v=1 in=2", req_granted[2], sa_valid, sa_ingress_port); end
    tick();
    drive(4'b0000, 1'b1, 2, 1'b0); tick();
  endtask

  task automatic test_random();
    logic [NB-1:0] rv;
    do_reset();
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(3) == 0) rv[b] = ~rv[b];
      for (int b = 0; b < NB; b++) begin
        req_egress_port[b] = PW'($urandom_range(3));
        req_vc[b]          = VW'($urandom_range(1));
      end
      if (m_last >= 0) drive(rv, 1'b1, m_last, $urandom_range(2) == 0);
      else             drive(rv, $urandom_range(3) == 0, $urandom_range(NB - 1), $urandom_range(1) == 1);
      total++; if (sa_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, sa_valid, exp_valid); end
      total++; if ({sa_ingress_port, sa_egress_port, sa_final_vc} !== {(exp_valid ? BW'(exp_win) : BW'(0)), exp_eg, exp_vc}) begin
        bad++; $display("FAIL rnd_fields cyc=%0d got in=%0d eg=%0d vc=%0d want in=%0d eg=%0d vc=%0d", c,
                        sa_ingress_port, sa_egress_port, sa_final_vc, exp_valid ? exp_win : 0, exp_eg, exp_vc); end
      total++; if (req_granted !== exp_gr) begin bad++; $display("FAIL rnd_granted cyc=%0d got=%b want=%b", c, req_granted, exp_gr); end
      tick();
    end
  endtask

  initial begin
    n_rst = 1'b0; cyc = 0; model_reset();
    req_valid = '0; req_egress_port = '0; req_vc = '0;
    resp_valid = 1'b0; resp_ingress_port = '0; resp_failed = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_rr_order();
    test_backoff();
    test_back_to_back();
    test_reset_pending();
    test_stray_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
